sseg_scan_monitor: RTL

SSEG_SCAN_MONITOR -- requirements
Module: sseg_scan_monitor

---
 rtl/sseg_scan_monitor.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_monitor.sv
// sseg_scan_monitor: samples a multiplexed 7-segment bus and rebuilds frames.
// Optional macro SSEG_MON_DP_EN: capture and publish per-digit decimal points.
module sseg_scan_monitor #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            sseg_ca,
    input  logic [DIGITS-1:0]     sseg_an,
    input  logic                  sseg_dp,
    output logic [4*DIGITS-1:0]   sseg,
    output logic [DIGITS-1:0]     dp,
    output logic                  frame_valid,
    output logic                  char_err,
    output logic                  scan_err,
    output logic [15:0]           frame_cnt
);

    localparam int IW = $clog2(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HELD
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [6:0]            r_ca;
    logic [6:0]            r_ca_q;
    logic [DIGITS-1:0]     r_an;
    logic [DIGITS-1:0]     r_an_q;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [3:0]            w_run;
    logic                  r_multi;
    logic                  w_multi_nxt;
    logic                  w_multi_err;
    logic                  w_cap;
    logic                  w_eval;
    logic [DIGITS-1:0]     r_mask;
    logic [DIGITS-1:0]     w_mask_new;
    logic [4*DIGITS-1:0]   r_stage;
    logic [4*DIGITS-1:0]   w_stage_new;
    logic [DIGITS-1:0]     r_stage_dp;
    logic [DIGITS-1:0]     w_stage_dp_new;
    logic [4*DIGITS-1:0]   r_sseg;
    logic [DIGITS-1:0]     r_dp_out;
    logic                  r_fv;
    logic                  r_cerr;
    logic                  r_serr;
    logic [15:0]           r_fcnt;
    logic [DIGITS-1:0]     w_low;
    logic                  w_none;
    logic                  w_one;
    logic                  w_multi;
    logic [IW-1:0]         w_idx;
    logic                  w_same;
    logic [4:0]            w_dec;
    logic                  w_last;
    logic                  w_full;

`ifdef SSEG_MON_DP_EN
    logic                  r_dp;
    logic                  r_dp_q;
`else
    logic                  w_unused_dp;
    assign w_unused_dp = sseg_dp;
`endif

    // Segment pattern to {error, nibble}; anything unknown reads as 0.
    function automatic logic [4:0] f_dec(input logic [6:0] c);
        case (c)
            7'b1000000: f_dec = 5'h00;
            7'b1111001: f_dec = 5'h01;
            7'b0100100: f_dec = 5'h02;
            7'b0110000: f_dec = 5'h03;
            7'b0011001: f_dec = 5'h04;
            7'b0010010: f_dec = 5'h05;
            7'b0000010: f_dec = 5'h06;
            7'b1111000: f_dec = 5'h07;
            7'b0000000: f_dec = 5'h08;
            7'b0010000: f_dec = 5'h09;
            7'b0001000: f_dec = 5'h0A;
            7'b0000011: f_dec = 5'h0B;
            7'b1000110: f_dec = 5'h0C;
            7'b0100001: f_dec = 5'h0D;
            7'b0000110: f_dec = 5'h0E;
            7'b0001110: f_dec = 5'h0F;
            default:    f_dec = 5'h10;
        endcase
    endfunction

    // Input sampling plus a one-cycle history for the stability compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ca   <= 7'h7F;
            r_ca_q <= 7'h7F;
            r_an   <= '1;
            r_an_q <= '1;
`ifdef SSEG_MON_DP_EN
            r_dp   <= 1'b1;
            r_dp_q <= 1'b1;
`endif
        end else begin
            r_ca   <= sseg_ca;
            r_ca_q <= r_ca;
            r_an   <= sseg_an;
            r_an_q <= r_an;
`ifdef SSEG_MON_DP_EN
            r_dp   <= sseg_dp;
            r_dp_q <= r_dp;
`endif
        end
    end

    // Classify the sampled anodes and find the active digit index.
    always_comb begin
        w_low  = ~r_an;
        w_none = (w_low == '0);
        w_one  = !w_none && ((w_low & (w_low - 1'b1)) == '0);
        w_multi = !w_none && !w_one;
        w_idx  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_low[i]) w_idx = IW'(i);
        end
        w_same = (r_an == r_an_q) && (r_ca == r_ca_q);
`ifdef SSEG_MON_DP_EN
        w_same = w_same && (r_dp == r_dp_q);
`endif
        w_dec  = f_dec(r_ca);
    end

    // Dwell state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_multi <= w_multi_nxt;
        end
    end

    // Dwell next-state: count identical samples, capture once per dwell.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_multi_nxt = 1'b0;
        w_multi_err = 1'b0;
        w_cap       = 1'b0;
        w_eval      = !((r_state == S_HELD) && (r_an == r_an_q));
        w_run       = ((r_state == S_SETTLE) && w_same) ? r_cnt + 4'd1 : 4'd1;
        if (w_multi) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_multi_nxt = 1'b1;
            w_multi_err = !r_multi;
        end else if (w_none) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_eval) begin
            w_cnt_nxt = w_run;
            if (w_run >= 4'(STABLE_CYCLES)) begin
                w_cap       = 1'b1;
                w_state_nxt = S_HELD;
            end else begin
                w_state_nxt = S_SETTLE;
            end
        end
    end

    // Staging contents as they will look once this cycle's capture lands.
    always_comb begin
        w_stage_new = r_stage;
        w_stage_new[4*w_idx +: 4] = w_dec[3:0];
        w_stage_dp_new = '0;
`ifdef SSEG_MON_DP_EN
        w_stage_dp_new = r_stage_dp;
        w_stage_dp_new[w_idx] = ~r_dp;
`endif
        w_mask_new = r_mask | (DIGITS'(1) << w_idx);
        w_last     = (w_idx == IW'(DIGITS - 1));
        w_full     = &w_mask_new;
    end

    // Staging buffer, mask, published frame and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage    <= '0;
            r_stage_dp <= '0;
            r_mask     <= '0;
            r_sseg     <= '0;
            r_dp_out   <= '0;
            r_fv       <= 1'b0;
            r_cerr     <= 1'b0;
            r_serr     <= 1'b0;
            r_fcnt     <= '0;
        end else begin
            r_fv   <= 1'b0;
            r_serr <= w_multi_err;
            if (w_cap) begin
                r_stage    <= w_stage_new;
                r_stage_dp <= w_stage_dp_new;
                r_mask     <= w_last ? '0 : w_mask_new;
                if (w_dec[4]) r_cerr <= 1'b1;
                if (w_last && w_full) begin
                    r_sseg   <= w_stage_new;
                    r_dp_out <= w_stage_dp_new;
                    r_fv     <= 1'b1;
                    r_fcnt   <= r_fcnt + 16'd1;
                end
                if (w_last && !w_full) r_serr <= 1'b1;
            end
        end
    end

    assign sseg        = r_sseg;
    assign dp          = r_dp_out;
    assign frame_valid = r_fv;
    assign char_err    = r_cerr;
    assign scan_err    = r_serr;
    assign frame_cnt   = r_fcnt;

endmodule
